multicycle_control: RTL and testbench

Moore-style control FSM for the multi-cycle MIPS datapath. One shared memory port, one ALU, IR/ALUOut/MDR registers in the datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath enable and mux select. Stalls on a memory ready handshake and traps illegal opcodes.

---
 rtl/mips_codes.sv | 91 +++++++++
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/mc_decode.sv | 53 +++++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_codes.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, ALU ops,
// datapath select values, opcodes and the packed control word.
package mips_codes;

   // FSM states; FETCH must stay at zero so the reset state reads back as 0.
   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StRExec    = 4'd2,
      StRWb      = 4'd3,
      StIExec    = 4'd4,
      StIWb      = 4'd5,
      StMemAddr  = 4'd6,
      StMemRead  = 4'd7,
      StMemWb    = 4'd8,
      StMemWrite = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11,
      StJr       = 4'd12,
      StTrap     = 4'd13
   } state_e;

   // ALU operation codes
   localparam logic [2:0] AluAdd   = 3'b000;
   localparam logic [2:0] AluSub   = 3'b001;
   localparam logic [2:0] AluAnd   = 3'b010;
   localparam logic [2:0] AluOr    = 3'b011;
   localparam logic [2:0] AluXor   = 3'b100;
   localparam logic [2:0] AluSlt   = 3'b101;
   localparam logic [2:0] AluFunct = 3'b111;

   // PC source select
   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;
   localparam logic [1:0] PcSrcRs     = 2'b11;

   // Register destination select
   localparam logic [1:0] RegDstRt = 2'b00;
   localparam logic [1:0] RegDstRd = 2'b01;
   localparam logic [1:0] RegDstRa = 2'b10;

   // Register write-data select
   localparam logic [1:0] Mem2RegAlu = 2'b00;
   localparam logic [1:0] Mem2RegMdr = 2'b01;
   localparam logic [1:0] Mem2RegPc  = 2'b10;

   // ALU B operand select
   localparam logic [1:0] AluBRt     = 2'b00;
   localparam logic [1:0] AluBFour   = 2'b01;
   localparam logic [1:0] AluBImm    = 2'b10;
   localparam logic [1:0] AluBImmSh2 = 2'b11;

   // Opcodes and R-type functs
   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpSlti  = 6'h0a;
   localparam logic [5:0] OpSltiu = 6'h0b;
   localparam logic [5:0] OpAndi  = 6'h0c;
   localparam logic [5:0] OpOri   = 6'h0d;
   localparam logic [5:0] OpXori  = 6'h0e;
   localparam logic [5:0] OpLui   = 6'h0f;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnJalr  = 6'h09;

   // Full set of datapath controls driven in one state
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem2reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       sign_xtend;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle: instruction fields and memory handshake in, all
// datapath enables and selects out.
interface multicycle_control_if #(
   parameter int unsigned ALUOP_W = 3
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               branch_ne;
   logic [1:0]         pc_src;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         mem2reg;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic               sign_xtend;
   logic               illegal;
   logic [3:0]         state_o;

   // Controller side
   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem2reg, alu_src_a, alu_src_b, alu_op,
             sign_xtend, illegal, state_o
   );

   // Datapath side
   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, mem_read, mem_write,
             ir_write, reg_write, reg_dst, mem2reg, alu_src_a, alu_src_b, alu_op,
             sign_xtend, illegal, state_o
   );
endinterface

// File: rtl/mc_decode.sv
// Instruction decode: successor of DECODE, and the ALU op / immediate extension
// used by I-type ALU instructions in I_EXEC.
module mc_decode
   import mips_codes::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output state_e     next_state_o,
   output logic [2:0] imm_alu_op_o,
   output logic       imm_sign_xtend_o
);

   // Instruction class selects the execute-phase state; unknown opcodes trap.
   always_comb begin
      next_state_o = StTrap;
      if (opcode_i == OpRType) begin
         next_state_o = (funct_i == FnJr || funct_i == FnJalr) ? StJr : StRExec;
      end else if (opcode_i[5:1] == 5'b00001) begin
         next_state_o = StJump;
      end else if (opcode_i[5:1] == 5'b00010) begin
         next_state_o = StBranch;
      end else if (opcode_i[5:3] == 3'b001) begin
         // LUI shares the I-ALU path; the datapath performs the shift.
         next_state_o = StIExec;
      end else if (opcode_i[5:3] == 3'b100 || opcode_i[5:2] == 4'b1010) begin
         next_state_o = StMemAddr;
      end
   end

   // I-type ALU op from the low opcode bits; logical ops zero-extend.
   always_comb begin
      imm_alu_op_o     = AluAdd;
      imm_sign_xtend_o = 1'b1;
      unique case (opcode_i[2:0])
         3'b000, 3'b001: imm_alu_op_o = AluAdd;
         3'b010, 3'b011: imm_alu_op_o = AluSlt;
         3'b100: begin
            imm_alu_op_o     = AluAnd;
            imm_sign_xtend_o = 1'b0;
         end
         3'b101, 3'b111: begin
            imm_alu_op_o     = AluOr;
            imm_sign_xtend_o = 1'b0;
         end
         3'b110: begin
            imm_alu_op_o     = AluXor;
            imm_sign_xtend_o = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives every
// datapath enable and select combinationally from the current state.
module multicycle_control
   import mips_codes::*;
#(
   parameter bit          HAS_MEM_READY = 1'b1,
   parameter int unsigned ALUOP_W       = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_control_if.master  ctrl_io
);

   state_e     state_q, state_d;
   state_e     dec_state;
   logic [2:0] imm_alu_op;
   logic       imm_sign_xtend;
   logic       mem_rdy;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;

   assign mem_rdy = HAS_MEM_READY ? ctrl_io.mem_ready : 1'b1;

   mc_decode u_decode (
      .opcode_i         (ctrl_io.opcode),
      .funct_i          (ctrl_io.funct),
      .next_state_o     (dec_state),
      .imm_alu_op_o     (imm_alu_op),
      .imm_sign_xtend_o (imm_sign_xtend)
   );

   // State register; reset aborts any instruction and returns to FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-state control word.
   always_comb begin
      state_d         = state_q;
      ctrl            = '0;
      ctrl.sign_xtend = 1'b1;
      unique case (state_q)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = AluBFour;
            ctrl.alu_op    = AluAdd;
            ctrl.pc_src    = PcSrcAlu;
            ctrl.ir_write  = mem_rdy;
            ctrl.pc_write  = mem_rdy;
            if (mem_rdy) state_d = StDecode;
         end
         StDecode: begin
            // Branch target into ALUOut ahead of knowing it is a branch.
            ctrl.alu_src_b = AluBImmSh2;
            ctrl.alu_op    = AluAdd;
            state_d        = dec_state;
         end
         StRExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = AluBRt;
            ctrl.alu_op    = AluFunct;
            state_d        = StRWb;
         end
         StRWb: begin
            ctrl.reg_dst   = RegDstRd;
            ctrl.mem2reg   = Mem2RegAlu;
            ctrl.reg_write = 1'b1;
            state_d        = StFetch;
         end
         StIExec: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = AluBImm;
            ctrl.alu_op     = imm_alu_op;
            ctrl.sign_xtend = imm_sign_xtend;
            state_d         = StIWb;
         end
         StIWb: begin
            ctrl.reg_dst   = RegDstRt;
            ctrl.mem2reg   = Mem2RegAlu;
            ctrl.reg_write = 1'b1;
            state_d        = StFetch;
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = AluBImm;
            ctrl.alu_op    = AluAdd;
            state_d        = ctrl_io.opcode[3] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
            if (mem_rdy) state_d = StMemWb;
         end
         StMemWb: begin
            ctrl.reg_dst   = RegDstRt;
            ctrl.mem2reg   = Mem2RegMdr;
            ctrl.reg_write = 1'b1;
            state_d        = StFetch;
         end
         StMemWrite: begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_write = 1'b1;
            if (mem_rdy) state_d = StFetch;
         end
         StBranch: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = AluBRt;
            ctrl.alu_op        = AluSub;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PcSrcAluOut;
            ctrl.branch_ne     = ctrl_io.opcode[0];
            state_d            = StFetch;
         end
         StJump: begin
            ctrl.pc_src   = PcSrcJump;
            ctrl.pc_write = 1'b1;
            if (ctrl_io.opcode == OpJal) begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = RegDstRa;
               ctrl.mem2reg   = Mem2RegPc;
            end
            state_d = StFetch;
         end
         StJr: begin
            ctrl.pc_src   = PcSrcRs;
            ctrl.pc_write = 1'b1;
            if (ctrl_io.funct[0]) begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = RegDstRd;
               ctrl.mem2reg   = Mem2RegPc;
            end
            state_d = StFetch;
         end
         StTrap: begin
            ctrl.illegal = 1'b1;
            state_d      = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   // Force every output low while reset is held so nothing glitches active.
   assign ctrl_gated = rst_n ? ctrl : '0;

   assign ctrl_io.pc_write      = ctrl_gated.pc_write;
   assign ctrl_io.pc_write_cond = ctrl_gated.pc_write_cond;
   assign ctrl_io.branch_ne     = ctrl_gated.branch_ne;
   assign ctrl_io.pc_src        = ctrl_gated.pc_src;
   assign ctrl_io.i_or_d        = ctrl_gated.i_or_d;
   assign ctrl_io.mem_read      = ctrl_gated.mem_read;
   assign ctrl_io.mem_write     = ctrl_gated.mem_write;
   assign ctrl_io.ir_write      = ctrl_gated.ir_write;
   assign ctrl_io.reg_write     = ctrl_gated.reg_write;
   assign ctrl_io.reg_dst       = ctrl_gated.reg_dst;
   assign ctrl_io.mem2reg       = ctrl_gated.mem2reg;
   assign ctrl_io.alu_src_a     = ctrl_gated.alu_src_a;
   assign ctrl_io.alu_src_b     = ctrl_gated.alu_src_b;
   assign ctrl_io.alu_op        = ALUOP_W'(ctrl_gated.alu_op);
   assign ctrl_io.sign_xtend    = ctrl_gated.sign_xtend;
   assign ctrl_io.illegal       = ctrl_gated.illegal;
   assign ctrl_io.state_o       = rst_n ? state_q : StFetch;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: instruction-level reference model pushes one expected
// control word per clock; a monitor pops and compares every cycle. A second
// instance with the memory handshake disabled runs SW forever alongside.
module tb_multicycle_control;
   import mips_codes::*;

   typedef struct packed {
      logic [3:0] st2;
      logic [3:0] st;
      logic       pcw, pcwc, bne;
      logic [1:0] pcs;
      logic       iord, mrd, mwr, irw, rw;
      logic [1:0] rdst, m2r;
      logic       srca;
      logic [1:0] srcb;
      logic [2:0] aop;
      logic       sx, ill;
   } word_t;

   typedef struct {
      word_t w;
      int    idx;
   } sb_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       mr;
      logic       rst;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_control_if #(.ALUOP_W(3)) bus ();
   multicycle_control_if #(.ALUOP_W(3)) bus2 ();

   multicycle_control #(.HAS_MEM_READY(1'b1), .ALUOP_W(3)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_io (bus)
   );

   multicycle_control #(.HAS_MEM_READY(1'b0), .ALUOP_W(3)) u_dut_nomr (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_io (bus2)
   );

   sb_t   sb_q[$];
   stim_t stim_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    inst_idx = 0;
   int    phase2 = 0;

   // Expected control word with everything idle.
   function automatic word_t blank(input logic [3:0] s);
      word_t w = '0;
      w.st = s;
      w.sx = 1'b1;
      return w;
   endfunction

   // Queue one cycle of expectation and its stimulus. The second instance
   // loops SW in exactly four cycles: FETCH, DECODE, MEM_ADDR, MEM_WRITE.
   task automatic put(input word_t w, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr);
      sb_t   e;
      stim_t s;
      case (phase2 % 4)
         0: w.st2 = StFetch;
         1: w.st2 = StDecode;
         2: w.st2 = StMemAddr;
         default: w.st2 = StMemWrite;
      endcase
      phase2++;
      e.w = w;
      e.idx = inst_idx;
      sb_q.push_back(e);
      s.op = op; s.fn = fn; s.mr = mr; s.rst = 1'b1;
      stim_q.push_back(s);
   endtask

   task automatic push_reset(input int n);
      sb_t   e;
      stim_t s;
      for (int i = 0; i < n; i++) begin
         e.w = '0;
         e.idx = inst_idx;
         sb_q.push_back(e);
         s.op = 6'h00; s.fn = 6'h00; s.mr = 1'b1; s.rst = 1'b0;
         stim_q.push_back(s);
      end
      phase2 = 0;
   endtask

   task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int nf);
      word_t w;
      for (int i = 0; i <= nf; i++) begin
         w = blank(StFetch);
         w.mrd = 1'b1;
         w.srcb = 2'b01;
         w.irw = (i == nf);
         w.pcw = (i == nf);
         put(w, op, fn, (i == nf));
      end
      w = blank(StDecode);
      w.srcb = 2'b11;
      put(w, op, fn, 1'($urandom_range(0, 1)));
   endtask

   function automatic logic [2:0] ialu_op(input int o);
      case (o)
         8, 9:    return 3'b000;
         10, 11:  return 3'b101;
         12:      return 3'b010;
         14:      return 3'b100;
         default: return 3'b011;
      endcase
   endfunction

   // Reference model of one instruction; nf/nm < 0 picks random stall counts.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int nf_i,
                        input int nm_i);
      int    o = int'(op);
      int    nf = (nf_i < 0) ? int'($urandom_range(0, 2)) : nf_i;
      int    nm = (nm_i < 0) ? int'($urandom_range(0, 3)) : nm_i;
      logic  r;
      word_t w;
      inst_idx++;
      fetch_decode(op, fn, nf);
      r = 1'($urandom_range(0, 1));
      if (o == 0 && (fn == 6'd8 || fn == 6'd9)) begin
         w = blank(StJr); w.pcs = 2'b11; w.pcw = 1'b1;
         if (fn == 6'd9) begin w.rw = 1'b1; w.rdst = 2'b01; w.m2r = 2'b10; end
         put(w, op, fn, r);
      end else if (o == 0) begin
         w = blank(StRExec); w.srca = 1'b1; w.aop = 3'b111;
         put(w, op, fn, r);
         w = blank(StRWb); w.rdst = 2'b01; w.rw = 1'b1;
         put(w, op, fn, r);
      end else if (o == 2 || o == 3) begin
         w = blank(StJump); w.pcs = 2'b10; w.pcw = 1'b1;
         if (o == 3) begin w.rw = 1'b1; w.rdst = 2'b10; w.m2r = 2'b10; end
         put(w, op, fn, r);
      end else if (o == 4 || o == 5) begin
         w = blank(StBranch); w.srca = 1'b1; w.aop = 3'b001; w.pcwc = 1'b1;
         w.pcs = 2'b01; w.bne = (o == 5);
         put(w, op, fn, r);
      end else if (o >= 8 && o <= 15) begin
         w = blank(StIExec); w.srca = 1'b1; w.srcb = 2'b10; w.aop = ialu_op(o);
         w.sx = (o < 12);
         put(w, op, fn, r);
         w = blank(StIWb); w.rw = 1'b1;
         put(w, op, fn, r);
      end else if (o >= 32 && o <= 43) begin
         w = blank(StMemAddr); w.srca = 1'b1; w.srcb = 2'b10;
         put(w, op, fn, r);
         for (int i = 0; i <= nm; i++) begin
            w = blank((o >= 40) ? StMemWrite : StMemRead);
            w.iord = 1'b1;
            if (o >= 40) w.mwr = 1'b1; else w.mrd = 1'b1;
            put(w, op, fn, (i == nm));
         end
         if (o < 40) begin
            w = blank(StMemWb); w.m2r = 2'b01; w.rw = 1'b1;
            put(w, op, fn, r);
         end
      end else begin
         w = blank(StTrap); w.ill = 1'b1;
         put(w, op, fn, r);
      end
   endtask

   // SW that is stalled in MEM_WRITE and then hit by reset.
   task automatic sw_abort();
      word_t w;
      inst_idx++;
      fetch_decode(6'h2b, 6'h00, 0);
      w = blank(StMemAddr); w.srca = 1'b1; w.srcb = 2'b10;
      put(w, 6'h2b, 6'h00, 1'b1);
      w = blank(StMemWrite); w.iord = 1'b1; w.mwr = 1'b1;
      put(w, 6'h2b, 6'h00, 1'b0);
      push_reset(2);
   endtask

   function automatic word_t grab();
      word_t w;
      w.st2 = bus2.state_o;  w.st = bus.state_o;
      w.pcw = bus.pc_write;  w.pcwc = bus.pc_write_cond; w.bne = bus.branch_ne;
      w.pcs = bus.pc_src;    w.iord = bus.i_or_d;        w.mrd = bus.mem_read;
      w.mwr = bus.mem_write; w.irw = bus.ir_write;       w.rw = bus.reg_write;
      w.rdst = bus.reg_dst;  w.m2r = bus.mem2reg;        w.srca = bus.alu_src_a;
      w.srcb = bus.alu_src_b; w.aop = bus.alu_op;        w.sx = bus.sign_xtend;
      w.ill = bus.illegal;
      return w;
   endfunction

   // Monitor: one expected word per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t   e;
         word_t act;
         e = sb_q.pop_front();
         act = grab();
         n_cmp++;
         if (act !== e.w) begin
            n_err++;
            $display("FAIL inst%0d ctrl_word: got %h expected %h", e.idx, act, e.w);
         end
      end
   end

   // Reset-state check: while reset is held, both instances sit in FETCH with
   // every enable and select low.
   always @(negedge clk) begin
      if (rst_n === 1'b0) begin
         n_cmp++;
         if (bus.state_o !== 4'd0 || bus2.state_o !== 4'd0 ||
             bus.pc_write !== 1'b0 || bus.pc_write_cond !== 1'b0 ||
             bus.ir_write !== 1'b0 || bus.reg_write !== 1'b0 ||
             bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
             bus.illegal !== 1'b0 || bus.pc_src !== 2'b00 ||
             bus.alu_op !== 3'b000 || bus2.mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state %0d/%0d mem_write %b mem_read %b",
                     bus.state_o, bus2.state_o, bus.mem_write, bus.mem_read);
         end
      end
   end

   logic [5:0] legal_ops [0:24] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
      6'h25, 6'h26, 6'h27, 6'h28, 6'h29, 6'h2a, 6'h2b};

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      bus.opcode = 6'h00;  bus.funct = 6'h00;  bus.mem_ready = 1'b0;
      bus2.opcode = 6'h2b; bus2.funct = 6'h00; bus2.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      push_reset(2);
      issue(6'h00, 6'h20, 0, 0);   // ADD
      issue(6'h23, 6'h00, 0, 3);   // LW, 3 wait cycles
      issue(6'h05, 6'h11, 0, 0);   // BNE
      issue(6'h04, 6'h00, 0, 0);   // BEQ
      issue(6'h03, 6'h00, 0, 0);   // JAL
      issue(6'h02, 6'h00, 0, 0);   // J
      issue(6'h00, 6'h09, 0, 0);   // JALR
      issue(6'h00, 6'h08, 0, 0);   // JR
      issue(6'h0d, 6'h00, 0, 0);   // ORI
      issue(6'h3f, 6'h00, 0, 0);   // illegal
      issue(6'h2b, 6'h00, 0, 0);   // SW
      issue(6'h00, 6'h22, 2, 0);   // SUB with fetch stalls
      sw_abort();
      for (int i = 0; i < 80; i++) begin
         op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 24)]
                                          : 6'($urandom_range(0, 63));
         if (op == 6'h0f) op = 6'h0e;
         fn = 6'($urandom_range(0, 63));
         if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'(8 + $urandom_range(0, 1));
         issue(op, fn, -1, -1);
      end
      sw_abort();
      issue(6'h0c, 6'h00, 1, 0);   // ANDI
      // Apply one stimulus entry per cycle, just after the rising edge.
      while (stim_q.size() > 0) begin
         stim_t s;
         s = stim_q.pop_front();
         bus.opcode = s.op;
         bus.funct = s.fn;
         bus.mem_ready = s.mr;
         rst_n = s.rst;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      // Expired-wait check: every expected cycle must have been consumed.
      if (sb_q.size() != 0 || n_cmp == 0) begin
         n_err++;
         $display("FAIL drain: %0d expected cycles never checked, %0d compared",
                  sb_q.size(), n_cmp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
